// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: line/word widths plus the arbiter's state and requester encodings.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;

    typedef enum logic [1:0] {
        arb_idle,
        arb_grant_i,
        arb_grant_d
    } lc3b_arb_state;

    typedef enum logic {
        req_i,
        req_d
    } lc3b_requester;

    // Byte-offset bits inside one 16-byte line; memory only ever sees line-aligned addresses.
    localparam int LINE_OFFSET_W = 4;

endpackage

// File: rtl/lc3b_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to whoever did not win last.
module lc3b_rr_pick (
    input  logic                        req_i,
    input  logic                        req_d,
    input  lc3b_types::lc3b_requester   last_grant,
    output logic                        valid,
    output lc3b_types::lc3b_requester   winner
);

    always_comb begin
        valid  = req_i | req_d;
        winner = lc3b_types::req_i;
        if (req_i && req_d) begin
            winner = (last_grant == lc3b_types::req_i) ? lc3b_types::req_d : lc3b_types::req_i;
        end else if (req_d) begin
            winner = lc3b_types::req_d;
        end
    end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Shares one physical-memory line port between the icache and dcache; one registered transaction
// at a time, round-robin on contention, with a watchdog that aborts transactions memory never answers.
module lc3b_mem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              timeout_err
);

    localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFFSET_W) - 1);

    lc3b_arb_state     state_reg, state_next;
    lc3b_requester     last_grant_reg, last_grant_next;
    logic              pmem_read_reg, pmem_read_next;
    logic              pmem_write_reg, pmem_write_next;
    logic [ADDR_W-1:0] pmem_address_reg, pmem_address_next;
    logic [LINE_W-1:0] pmem_wdata_reg, pmem_wdata_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              timeout_err_reg, timeout_err_next;

    logic              pick_valid;
    lc3b_requester     pick_winner;

    lc3b_rr_pick u_rr_pick (
        .req_i      (i_read | i_write),
        .req_d      (d_read | d_write),
        .last_grant (last_grant_reg),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        state_next        = state_reg;
        last_grant_next   = last_grant_reg;
        pmem_read_next    = pmem_read_reg;
        pmem_write_next   = pmem_write_reg;
        pmem_address_next = pmem_address_reg;
        pmem_wdata_next   = pmem_wdata_reg;
        count_next        = count_reg;
        timeout_err_next  = timeout_err_reg;

        case (state_reg)
            arb_idle: begin
                // pmem_resp is deliberately not looked at here: late or spurious responses are dropped.
                if (pick_valid) begin
                    last_grant_next = pick_winner;
                    count_next      = '0;
                    if (pick_winner == req_d) begin
                        state_next        = arb_grant_d;
                        pmem_address_next = d_address & LINE_MASK;
                        pmem_wdata_next   = d_wdata;
                        pmem_write_next   = d_write;
                        pmem_read_next    = !d_write;
                    end else begin
                        state_next        = arb_grant_i;
                        pmem_address_next = i_address & LINE_MASK;
                        pmem_wdata_next   = i_wdata;
                        pmem_write_next   = i_write;
                        pmem_read_next    = !i_write;
                    end
                end
            end
            arb_grant_i, arb_grant_d: begin
                if (pmem_resp) begin
                    state_next      = arb_idle;
                    pmem_read_next  = 1'b0;
                    pmem_write_next = 1'b0;
                end else if (TIMEOUT > 0 && count_reg == CNT_LAST) begin
                    // This cycle is the TIMEOUT-th unanswered one, so the strobe was high exactly TIMEOUT cycles.
                    state_next       = arb_idle;
                    pmem_read_next   = 1'b0;
                    pmem_write_next  = 1'b0;
                    timeout_err_next = 1'b1;
                end else if (count_reg != '1) begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next      = arb_idle;
                pmem_read_next  = 1'b0;
                pmem_write_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= arb_idle;
            last_grant_reg   <= req_i;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            pmem_address_reg <= '0;
            pmem_wdata_reg   <= '0;
            count_reg        <= '0;
            timeout_err_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            last_grant_reg   <= last_grant_next;
            pmem_read_reg    <= pmem_read_next;
            pmem_write_reg   <= pmem_write_next;
            pmem_address_reg <= pmem_address_next;
            pmem_wdata_reg   <= pmem_wdata_next;
            count_reg        <= count_next;
            timeout_err_reg  <= timeout_err_next;
        end
    end

    assign i_resp       = (state_reg == arb_grant_i) && pmem_resp;
    assign d_resp       = (state_reg == arb_grant_d) && pmem_resp;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;
    assign pmem_read    = pmem_read_reg;
    assign pmem_write   = pmem_write_reg;
    assign pmem_address = pmem_address_reg;
    assign pmem_wdata   = pmem_wdata_reg;
    assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Bench for lc3b_mem_arbiter: expected memory transactions are queued as requests are driven and
// checked against the pmem port when a grant appears; a small memory model answers them.
module tb_lc3b_mem_arbiter;

    localparam int TO = 8;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [127:0] wdata;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, i_write, d_read, d_write;
    logic [15:0]  i_address, d_address;
    logic [127:0] i_wdata, d_wdata;
    logic         i_resp, d_resp;
    logic [127:0] i_rdata, d_rdata;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         timeout_err;

    int   checks   = 0;
    int   failures = 0;
    txn_t exp_q[$];
    txn_t cur;

    always #5 clk = ~clk;

    lc3b_mem_arbiter #(.ADDR_W(16), .LINE_W(128), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_address    (i_address),
        .i_wdata      (i_wdata),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .timeout_err  (timeout_err)
    );

    function automatic txn_t mk(input bit is_d, input bit wr, input logic [15:0] addr,
                                input logic [127:0] wdata);
        txn_t t;
        t.is_d  = is_d;
        t.wr    = wr;
        t.addr  = {addr[15:4], 4'h0};
        t.wdata = wdata;
        return t;
    endfunction

    // Memory side, grant phase: wait (bounded) for a strobe, pop the expected transaction, compare.
    task automatic mem_wait_grant(output int lat);
        lat = 0;
        while (!(pmem_read || pmem_write) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat >= 20) begin
            failures++;
            $display("FAIL grant_timeout: no pmem strobe after %0d cycles, required one", lat);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: pmem strobe seen at addr %h, required none", pmem_address);
            return;
        end
        cur = exp_q.pop_front();
        checks++;
        if (pmem_write !== cur.wr || pmem_read !== !cur.wr) begin
            failures++;
            $display("FAIL grant_op: pmem_read=%b pmem_write=%b, required write=%b", pmem_read, pmem_write, cur.wr);
        end
        checks++;
        if (pmem_address !== cur.addr) begin
            failures++;
            $display("FAIL grant_addr: pmem_address=%h, required %h", pmem_address, cur.addr);
        end
        if (cur.wr) begin
            checks++;
            if (pmem_wdata !== cur.wdata) begin
                failures++;
                $display("FAIL grant_wdata: pmem_wdata=%h, required %h", pmem_wdata, cur.wdata);
            end
        end
        $display("grant  %s %s addr=%h lat=%0d", cur.is_d ? "D" : "I", cur.wr ? "WR" : "RD", pmem_address, lat);
    endtask

    // Memory side, response phase: answer the current transaction and check both resp lines.
    task automatic mem_complete(input logic [127:0] rdata, input bit release_req);
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        #1;
        checks++;
        if (i_resp !== !cur.is_d || d_resp !== cur.is_d) begin
            failures++;
            $display("FAIL resp_route: i_resp=%b d_resp=%b, required i=%b d=%b", i_resp, d_resp, !cur.is_d, cur.is_d);
        end
        checks++;
        if (i_rdata !== rdata || d_rdata !== rdata) begin
            failures++;
            $display("FAIL rdata: i_rdata=%h d_rdata=%h, required %h", i_rdata, d_rdata, rdata);
        end
        checks++;
        if (pmem_address !== cur.addr || (cur.wr && pmem_wdata !== cur.wdata)) begin
            failures++;
            $display("FAIL held_regs: pmem_address=%h pmem_wdata=%h, required %h %h", pmem_address, pmem_wdata, cur.addr, cur.wdata);
        end
        if (release_req) begin
            if (cur.is_d) begin d_read = 1'b0; d_write = 1'b0; end
            else          begin i_read = 1'b0; i_write = 1'b0; end
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
            failures++;
            $display("FAIL after_resp: read=%b write=%b i_resp=%b d_resp=%b, required all 0", pmem_read, pmem_write, i_resp, d_resp);
        end
        $display("resp   %s rdata=%h", cur.is_d ? "D" : "I", rdata);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== 16'h0 || pmem_wdata !== 128'h0 ||
            i_resp !== 1'b0 || d_resp !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: rd=%b wr=%b addr=%h wdata=%h ir=%b dr=%b err=%b, required all 0",
                     pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp, timeout_err);
        end
        $display("reset  outputs rd=%b wr=%b addr=%h err=%b", pmem_read, pmem_write, pmem_address, timeout_err);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        int lat;
        i_read = 1'b1; i_address = 16'h1234;
        exp_q.push_back(mk(0, 0, 16'h1234, '0));
        mem_wait_grant(lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL read_latency: %0d cycles, required 1", lat);
        end
        @(negedge clk);
        mem_complete({8{16'hA5A5}}, 1'b1);
    endtask

    task automatic test_round_robin();
        int lat;
        apply_reset();
        i_read = 1'b1; i_address = 16'h2004;
        d_write = 1'b1; d_address = 16'h300F; d_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back(mk(1, 1, d_address, d_wdata));
            else            exp_q.push_back(mk(0, 0, i_address, '0));
        end
        for (int k = 0; k < 4; k++) begin
            mem_wait_grant(lat);
            checks++;
            if (lat !== 1) begin
                failures++;
                $display("FAIL rr_bubble%0d: grant after %0d cycles, required 1", k, lat);
            end
            mem_complete({4{32'hC0DE_0000 + 32'(k)}}, k >= 2);
        end
    endtask

    task automatic test_stable_latch();
        int lat;
        d_write = 1'b1; d_address = 16'h5A5F; d_wdata = {4{32'hDEAD_BEEF}};
        exp_q.push_back(mk(1, 1, 16'h5A5F, {4{32'hDEAD_BEEF}}));
        mem_wait_grant(lat);
        d_address = 16'hFFFF; d_wdata = ~{4{32'hDEAD_BEEF}};
        repeat (2) @(negedge clk);
        checks++;
        if (pmem_address !== 16'h5A50 || pmem_wdata !== {4{32'hDEAD_BEEF}}) begin
            failures++;
            $display("FAIL latch_hold: addr=%h wdata=%h, required 5a50 %h", pmem_address, pmem_wdata, {4{32'hDEAD_BEEF}});
        end
        mem_complete(128'h1, 1'b1);
    endtask

    task automatic test_timeout_edge();
        int lat;
        d_read = 1'b1; d_address = 16'h7770;
        exp_q.push_back(mk(1, 0, 16'h7770, '0));
        mem_wait_grant(lat);
        repeat (TO - 1) @(negedge clk);
        mem_complete({2{64'h0F0F_0F0F_0F0F_0F0F}}, 1'b1);
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_edge_err: timeout_err=%b, required 0", timeout_err);
        end
    endtask

    task automatic test_timeout();
        int lat;
        int high;
        bit saw_resp;
        d_read = 1'b1; d_address = 16'h8880;
        exp_q.push_back(mk(1, 0, 16'h8880, '0));
        mem_wait_grant(lat);
        high = 1;
        saw_resp = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d_resp || i_resp) saw_resp = 1'b1;
            if (!pmem_read) break;
            high++;
        end
        d_read = 1'b0;
        checks++;
        if (high !== TO) begin
            failures++;
            $display("FAIL timeout_len: strobe high %0d cycles, required %0d", high, TO);
        end
        checks++;
        if (saw_resp !== 1'b0 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort: resp_seen=%b timeout_err=%b, required 0 1", saw_resp, timeout_err);
        end
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
            failures++;
            $display("FAIL idle_resp: i_resp=%b d_resp=%b, required 0 0", i_resp, d_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL idle_ignore: rd=%b wr=%b err=%b, required 0 0 1", pmem_read, pmem_write, timeout_err);
        end
        $display("abort  D strobe_cycles=%0d timeout_err=%b", high, timeout_err);
    endtask

    task automatic test_reset_mid();
        int lat;
        i_read = 1'b1; i_address = 16'h9ABC;
        exp_q.push_back(mk(0, 0, 16'h9ABC, '0));
        mem_wait_grant(lat);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0 || timeout_err !== 1'b0 || pmem_address !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid: rd=%b err=%b addr=%h, required 0 0 0000", pmem_read, timeout_err, pmem_address);
        end
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 0, 16'h9ABC, '0));
        mem_wait_grant(lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL regrant_latency: %0d cycles, required 1", lat);
        end
        mem_complete({16{8'h3C}}, 1'b1);
    endtask

    task automatic test_read_write_both();
        int lat;
        i_read = 1'b1; i_write = 1'b1; i_address = 16'h4321; i_wdata = {8{16'hBEEF}};
        exp_q.push_back(mk(0, 1, 16'h4321, {8{16'hBEEF}}));
        mem_wait_grant(lat);
        mem_complete('0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        i_read = 1'b0; i_write = 1'b0; i_address = '0; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;

        test_reset();
        test_single_read();
        test_round_robin();
        test_stable_latch();
        test_timeout_edge();
        test_timeout();
        test_reset_mid();
        test_read_write_both();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: %0d transactions never granted, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
